// File: rtl/hdmi_timing_gen_p_if.sv
// Video-side bundle of the HDMI raster timing generator: control inputs,
// line-buffer pixel input, sync/RGB outputs and frame-buffer read requests.
interface hdmi_timing_gen_p_if #(
  parameter int HW = 12,
  parameter int VW = 11
);
  logic          start;
  logic          stop;
  logic [HW-1:0] hres;
  logic [VW-1:0] vres;
  logic [23:0]   pixel_in;
  logic          pixel_valid;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic          hsync;
  logic          vsync;
  logic          ve;
  logic          read_go;
  logic          read_next_line;
  logic          read_next_chunk;
  logic          read_done;
  logic          underflow;
  logic [15:0]   frame_count;
  logic          busy;

  // master: the timing generator; slave: the controller/sink around it
  modport master (
    input  start, stop, hres, vres, pixel_in, pixel_valid,
    output red, green, blue, hsync, vsync, ve,
           read_go, read_next_line, read_next_chunk, read_done,
           underflow, frame_count, busy
  );

  modport slave (
    output start, stop, hres, vres, pixel_in, pixel_valid,
    input  red, green, blue, hsync, vsync, ve,
           read_go, read_next_line, read_next_chunk, read_done,
           underflow, frame_count, busy
  );
endinterface

// File: rtl/hdmi_timing_gen_p.sv
// HDMI raster timing generator: programmable active area, fixed porches,
// registered sync/RGB outputs and frame/line/chunk read-request pulses.
module hdmi_timing_gen_p #(
  parameter int HW     = 12,
  parameter int VW     = 11,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int CHUNK  = 32
) (
  input  logic               clock,
  input  logic               reset,
  hdmi_timing_gen_p_if.master bus
);
  localparam int CW = $clog2(CHUNK);
  localparam logic [HW-1:0] HFP  = HW'(H_FP);
  localparam logic [HW-1:0] HSY  = HW'(H_SYNC);
  localparam logic [HW-1:0] HBP  = HW'(H_BP);
  localparam logic [VW-1:0] VFP  = VW'(V_FP);
  localparam logic [VW-1:0] VSY  = VW'(V_SYNC);
  localparam logic [VW-1:0] VBP  = VW'(V_BP);
  localparam logic [CW-1:0] CLST = CW'(CHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [HW-1:0] hcount, hr;
  logic [VW-1:0] vcount, vr;

  logic [7:0]  red_q, green_q, blue_q;
  logic        hsync_q, vsync_q, ve_q;
  logic        go_q, nline_q, nchunk_q, done_q, uflow_q, busy_q;
  logic [15:0] fcount_q;

  // Region boundaries derived from the latched resolution
  logic [HW-1:0] hs_beg, hs_end, ht;
  logic [VW-1:0] vs_beg, vs_end, vt;
  logic          active, hs_act, vs_act, chunk_end, line_end, last_line;
  logic          frame_end;

  always_comb begin
    hs_beg    = hr + HFP;
    hs_end    = hs_beg + HSY;
    ht        = hs_end + HBP;
    vs_beg    = vr + VFP;
    vs_end    = vs_beg + VSY;
    vt        = vs_end + VBP;
    active    = (hcount < hr) && (vcount < vr);
    hs_act    = (hcount >= hs_beg) && (hcount < hs_end);
    vs_act    = (vcount >= vs_beg) && (vcount < vs_end);
    // A short final chunk still needs its own advance pulse
    chunk_end = active && ((hcount[CW-1:0] == CLST) || (hcount == hr - HW'(1)));
    line_end  = (hcount == hr) && (vcount < vr);
    last_line = (vcount == vr - VW'(1));
    frame_end = (hcount == ht - HW'(1)) && (vcount == vt - VW'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      hcount   <= '0;
      vcount   <= '0;
      hr       <= '0;
      vr       <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      ve_q     <= 1'b0;
      go_q     <= 1'b0;
      nline_q  <= 1'b0;
      nchunk_q <= 1'b0;
      done_q   <= 1'b0;
      uflow_q  <= 1'b0;
      fcount_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          go_q     <= 1'b0;
          nline_q  <= 1'b0;
          nchunk_q <= 1'b0;
          done_q   <= 1'b0;
          if (bus.start) begin
            state   <= RUN;
            hr      <= bus.hres;
            vr      <= bus.vres;
            hcount  <= '0;
            vcount  <= '0;
            go_q    <= 1'b1;
            uflow_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          if (active && bus.pixel_valid) begin
            red_q   <= bus.pixel_in[23:16];
            green_q <= bus.pixel_in[15:8];
            blue_q  <= bus.pixel_in[7:0];
          end else begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
          end
          hsync_q  <= hs_act ? HS_POL : ~HS_POL;
          vsync_q  <= vs_act ? VS_POL : ~VS_POL;
          ve_q     <= active;
          nchunk_q <= chunk_end;
          nline_q  <= line_end && !last_line;
          done_q   <= line_end && last_line;
          go_q     <= 1'b0;
          if (active && !bus.pixel_valid) uflow_q <= 1'b1;

          if (frame_end) begin
            fcount_q <= fcount_q + 16'd1;
            hcount   <= '0;
            vcount   <= '0;
            if (state == DRAIN || bus.stop) begin
              // Last pixel sits in the back porch, so idle levels are already correct
              state   <= IDLE;
              busy_q  <= 1'b0;
              red_q   <= '0;
              green_q <= '0;
              blue_q  <= '0;
              hsync_q <= ~HS_POL;
              vsync_q <= ~VS_POL;
              ve_q    <= 1'b0;
            end else begin
              hr   <= bus.hres;
              vr   <= bus.vres;
              go_q <= 1'b1;
            end
          end else begin
            if (hcount == ht - HW'(1)) begin
              hcount <= '0;
              vcount <= vcount + VW'(1);
            end else begin
              hcount <= hcount + HW'(1);
            end
            if (state == RUN && bus.stop) state <= DRAIN;
          end
        end
      endcase
    end
  end

  assign bus.red             = red_q;
  assign bus.green           = green_q;
  assign bus.blue            = blue_q;
  assign bus.hsync           = hsync_q;
  assign bus.vsync           = vsync_q;
  assign bus.ve              = ve_q;
  assign bus.read_go         = go_q;
  assign bus.read_next_line  = nline_q;
  assign bus.read_next_chunk = nchunk_q;
  assign bus.read_done       = done_q;
  assign bus.underflow       = uflow_q;
  assign bus.frame_count     = fcount_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_hdmi_timing_gen_p.sv
// Randomized bench: a raster-position model predicts every output each cycle.
module tb_hdmi_timing_gen_p;
  localparam int HW = 12, VW = 11;
  localparam int HFP = 6, HSY = 4, HBP = 5, VFP = 2, VSY = 2, VBP = 3, CHK = 8;
  localparam bit HSP = 1'b1, VSP = 1'b0;
  localparam int CYCLES = 40000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hdmi_timing_gen_p_if #(.HW(HW), .VW(VW)) bus ();

  hdmi_timing_gen_p #(
    .HW(HW), .VW(VW), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .HS_POL(HSP), .VS_POL(VSP), .CHUNK(CHK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Model: mode 0 idle, 1 running, 2 draining; (mx,my) is the raster position
  int mode, mx, my, mhr, mvr;
  logic [23:0] e_rgb;
  logic e_hs, e_vs, e_ve, e_go, e_nl, e_nc, e_done, e_uf, e_busy;
  logic [15:0] e_fc;

  task automatic model_idle_outputs();
    e_rgb = 0; e_hs = !HSP; e_vs = !VSP; e_ve = 0;
    e_go = 0; e_nl = 0; e_nc = 0; e_done = 0;
  endtask

  task automatic model_edge();
    int ht, vt;
    bit act, fend;
    if (reset) begin
      model_idle_outputs();
      mode = 0; mx = 0; my = 0; e_uf = 0; e_fc = 0; e_busy = 0;
      return;
    end
    if (mode == 0) begin
      e_go = 0; e_nl = 0; e_nc = 0; e_done = 0;
      if (bus.start) begin
        mode = 1; mhr = int'(bus.hres); mvr = int'(bus.vres);
        mx = 0; my = 0; e_go = 1; e_uf = 0; e_busy = 1;
      end
      return;
    end
    ht = mhr + HFP + HSY + HBP;
    vt = mvr + VFP + VSY + VBP;
    act = (mx < mhr) && (my < mvr);
    e_ve = act;
    e_rgb = (act && bus.pixel_valid) ? bus.pixel_in : 24'h0;
    if (act && !bus.pixel_valid) e_uf = 1;
    e_hs = ((mx >= mhr + HFP) && (mx < mhr + HFP + HSY)) ? HSP : !HSP;
    e_vs = ((my >= mvr + VFP) && (my < mvr + VFP + VSY)) ? VSP : !VSP;
    e_nc = act && ((mx % CHK) == CHK - 1 || mx == mhr - 1);
    e_nl = (mx == mhr) && (my + 1 < mvr);
    e_done = (mx == mhr) && (my + 1 == mvr);
    e_go = 0;
    fend = (mx == ht - 1) && (my == vt - 1);
    if (fend) begin
      e_fc = e_fc + 16'd1;
      mx = 0; my = 0;
      if (mode == 2 || bus.stop) begin
        mode = 0; e_busy = 0;
        model_idle_outputs();
      end else begin
        mhr = int'(bus.hres); mvr = int'(bus.vres); e_go = 1;
      end
    end else begin
      mx++;
      if (mx == ht) begin mx = 0; my++; end
      if (mode == 1 && bus.stop) mode = 2;
    end
  endtask

  task automatic compare_all();
    chk("rgb", {8'h0, bus.red, bus.green, bus.blue}, {8'h0, e_rgb});
    chk("hsync", bus.hsync, e_hs);
    chk("vsync", bus.vsync, e_vs);
    chk("ve", bus.ve, e_ve);
    chk("read_go", bus.read_go, e_go);
    chk("read_next_line", bus.read_next_line, e_nl);
    chk("read_next_chunk", bus.read_next_chunk, e_nc);
    chk("read_done", bus.read_done, e_done);
    chk("underflow", bus.underflow, e_uf);
    chk("frame_count", bus.frame_count, e_fc);
    chk("busy", bus.busy, e_busy);
  endtask

  task automatic drive_random();
    reset = ($urandom_range(0, 4999) == 0);
    bus.start = ($urandom_range(0, 15) == 0);
    bus.stop = ($urandom_range(0, 899) == 0);
    if ($urandom_range(0, 63) == 0) begin
      bus.hres = HW'($urandom_range(1, 40));
      bus.vres = VW'($urandom_range(1, 6));
    end
    bus.pixel_in = 24'($urandom());
    bus.pixel_valid = ($urandom_range(0, 15) != 0);
  endtask

  int n_go, n_done;

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.stop = 0; bus.hres = HW'(20); bus.vres = VW'(3);
    bus.pixel_in = 0; bus.pixel_valid = 1;
    mode = 0; mx = 0; my = 0; mhr = 0; mvr = 0; e_fc = 0; e_uf = 0; e_busy = 0;
    model_idle_outputs();
    n_go = 0; n_done = 0;
    repeat (3) begin
      @(posedge clock); model_edge(); #1 compare_all();
    end
    reset = 1'b0;
    // Directed start: hres a multiple of CHUNK, then a short final chunk after re-latch
    bus.hres = HW'(16); bus.vres = VW'(2); bus.start = 1;
    @(posedge clock); model_edge(); #1 compare_all();
    bus.start = 0; bus.hres = HW'(13); bus.vres = VW'(3);
    for (int c = 0; c < CYCLES; c++) begin
      @(posedge clock); model_edge(); #1 compare_all();
      if (e_go) n_go++;
      if (e_done) n_done++;
      if (c > 400) drive_random();
    end
    chk("frames_seen", (n_go > 5 && n_done > 5) ? 32'd1 : 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
